// File: rtl/spi_readback.sv
// spi_readback: SPI slave readback transmitter on the ARM-to-FPGA return path.
// Oversamples spck/ncs/mosi in the ck_1356meg domain and decodes the 16-bit
// read frame header (cmd[15:12], addr[11:8]). It then shifts the selected
// 8-bit register out on miso, MSB first, during the data slot of the same
// frame. Completed and malformed frames are counted for link diagnostics.
//
// Ports:
//   ck_1356meg  in   sole clock, rising edge
//   nrst        in   asynchronous active-low reset
//   spck        in   SPI clock from ARM (asynchronous)
//   ncs         in   SPI chip select, active-low (asynchronous)
//   mosi        in   SPI data from ARM (asynchronous)
//   conf_word   in   readback source, addr 0
//   divisor     in   readback source, addr 1
//   conf_enio   in   readback source, addr 2
//   status      in   live status byte, addr 3
//   miso        out  SPI data to ARM
//   miso_oe     out  high while miso carries read data
//   rd_done     out  one-cycle pulse, read frame completed with 16 bits
//   frame_err   out  one-cycle pulse, frame ended with 1..15 or >16 bits
//
// state | meaning
// IDLE  | waiting for a chip-select falling edge
// HDR   | shifting in command/address bits 15..8
// DATA  | read decoded, shifting the snapshot byte out on miso
// DRAIN | ignoring edges until chip select rises
module spi_readback #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [3:0]  CMD_READ    = 4'b1000
) (
  input  logic       ck_1356meg,
  input  logic       nrst,
  input  logic       spck,
  input  logic       ncs,
  input  logic       mosi,
  input  logic [7:0] conf_word,
  input  logic [7:0] divisor,
  input  logic [7:0] conf_enio,
  input  logic [7:0] status,
  output logic       miso,
  output logic       miso_oe,
  output logic       rd_done,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DRAIN} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] spck_sync, ncs_sync, mosi_sync;
  logic s_spck, s_ncs, s_mosi;
  logic spck_d, ncs_d;
  logic rise, fall, ncs_rise, ncs_fall;

  logic [4:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] frame_cnt;
  logic [7:0] err_cnt;
  logic       oe_q;
  logic       is_rd;
  logic       rd_done_q;
  logic       frame_err_q;

  logic [7:0] hdr_byte;
  logic       hdr_is_read;
  logic       decode_now;
  logic [7:0] rd_src;

  // The ncs synchronizer resets to 0 (not the idle 1) so that a reset
  // released in the middle of a frame never produces a falling edge; the
  // block only arms after it has seen ncs high.
  always_ff @(posedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      spck_sync <= '0;
      ncs_sync  <= '0;
      mosi_sync <= '0;
      spck_d    <= 1'b0;
      ncs_d     <= 1'b0;
    end else begin
      spck_sync <= {spck_sync[SYNC_STAGES-2:0], spck};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      spck_d    <= s_spck;
      ncs_d     <= s_ncs;
    end
  end

  assign s_spck   = spck_sync[SYNC_STAGES-1];
  assign s_ncs    = ncs_sync[SYNC_STAGES-1];
  assign s_mosi   = mosi_sync[SYNC_STAGES-1];
  assign rise     = s_spck & ~spck_d & ~s_ncs;
  assign fall     = ~s_spck & spck_d & ~s_ncs;
  assign ncs_rise = s_ncs & ~ncs_d;
  assign ncs_fall = ~s_ncs & ncs_d;

  // Header byte including the bit arriving on the current rise.
  assign hdr_byte    = {rx_shift[6:0], s_mosi};
  assign hdr_is_read = (hdr_byte[7:4] == CMD_READ);
  assign decode_now  = (state == HDR) && rise && (bit_cnt == 5'd7);

  always_comb begin
    rd_src = 8'h00;
    case (hdr_byte[3:0])
      4'd0:    rd_src = conf_word;
      4'd1:    rd_src = divisor;
      4'd2:    rd_src = conf_enio;
      4'd3:    rd_src = status;
      4'd4:    rd_src = frame_cnt;
      4'd5:    rd_src = err_cnt;
      default: rd_src = 8'h00;
    endcase
  end

  always_ff @(posedge ck_1356meg or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ncs_rise) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (ncs_fall) state_nxt = HDR;
        HDR:     if (decode_now) state_nxt = hdr_is_read ? DATA : DRAIN;
        DATA:    if (rise && bit_cnt == 5'd15) state_nxt = DRAIN;
        DRAIN:   state_nxt = DRAIN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Edges seen while IDLE with ncs low (only possible after a mid-frame
  // reset) are not counted, so the remainder of such a frame is ignored.
  always_ff @(posedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      bit_cnt  <= 5'd0;
      rx_shift <= 8'h00;
    end else begin
      if (s_ncs) begin
        bit_cnt <= 5'd0;
      end else if (rise && state != IDLE && bit_cnt != 5'd31) begin
        bit_cnt <= bit_cnt + 5'd1;
      end
      if (rise) rx_shift <= hdr_byte;
    end
  end

  // Bit 7 is presented right after the 8th rise and must survive the fall
  // that follows it, since the ARM samples it on rise 9; shifting therefore
  // starts with the fall after rise 9.
  always_ff @(posedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      tx_shift <= 8'h00;
      oe_q     <= 1'b0;
      is_rd    <= 1'b0;
    end else if (ncs_rise) begin
      tx_shift <= 8'h00;
      oe_q     <= 1'b0;
      is_rd    <= 1'b0;
    end else if (decode_now && hdr_is_read) begin
      tx_shift <= rd_src;
      oe_q     <= 1'b1;
      is_rd    <= 1'b1;
    end else if (state == DATA && fall && bit_cnt > 5'd8) begin
      tx_shift <= {tx_shift[6:0], 1'b0};
    end
  end

  always_ff @(posedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      frame_cnt   <= 8'h00;
      err_cnt     <= 8'h00;
      rd_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rd_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      if (ncs_rise && state != IDLE) begin
        if (bit_cnt == 5'd16) begin
          frame_cnt <= frame_cnt + 8'd1;
          rd_done_q <= is_rd;
        end else if (bit_cnt != 5'd0) begin
          frame_err_q <= 1'b1;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

  always_comb begin
    miso_oe   = oe_q;
    miso      = oe_q & tx_shift[7];
    rd_done   = rd_done_q;
    frame_err = frame_err_q;
  end

endmodule

// File: tb/tb_spi_readback.sv
`timescale 1ns/1ps
module tb_spi_readback;

  localparam int PH   = 6;
  localparam int SYNC = 2;

  logic       ck_1356meg = 1'b0;
  logic       nrst;
  logic       spck;
  logic       ncs;
  logic       mosi;
  logic [7:0] conf_word;
  logic [7:0] divisor;
  logic [7:0] conf_enio;
  logic [7:0] status;
  logic       miso;
  logic       miso_oe;
  logic       rd_done;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  logic [15:0] cur_word;
  int          bit_idx;
  logic [7:0]  rx_byte;
  logic        oe_hdr;
  logic        oe_data;
  int          n_rd;
  int          n_err;
  logic        oe_late;

  spi_readback #(.SYNC_STAGES(SYNC), .CMD_READ(4'b1000)) dut (
    .ck_1356meg (ck_1356meg),
    .nrst       (nrst),
    .spck       (spck),
    .ncs        (ncs),
    .mosi       (mosi),
    .conf_word  (conf_word),
    .divisor    (divisor),
    .conf_enio  (conf_enio),
    .status     (status),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .rd_done    (rd_done),
    .frame_err  (frame_err)
  );

  always #37 ck_1356meg = ~ck_1356meg;

  task automatic tick(input int n);
    repeat (n) @(negedge ck_1356meg);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_start(input logic [15:0] w);
    cur_word = w;
    bit_idx  = 0;
    rx_byte  = 8'h00;
    oe_hdr   = 1'b0;
    oe_data  = 1'b1;
    ncs      = 1'b0;
    tick(PH);
  endtask

  // One SPI bit: set mosi, sample miso/miso_oe as the ARM would at the
  // rising spck edge, then high phase and falling edge.
  task automatic spi_bit();
    mosi = (bit_idx < 16) ? cur_word[15-bit_idx] : 1'b0;
    tick(PH);
    if (bit_idx < 8) begin
      oe_hdr = oe_hdr | miso_oe;
    end else if (bit_idx < 16) begin
      oe_data = oe_data & miso_oe;
      rx_byte = {rx_byte[6:0], miso};
    end
    spck = 1'b1;
    tick(PH);
    spck = 1'b0;
    bit_idx++;
  endtask

  task automatic spi_end();
    tick(PH);
    ncs     = 1'b1;
    n_rd    = 0;
    n_err   = 0;
    oe_late = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick(1);
      if (rd_done)   n_rd++;
      if (frame_err) n_err++;
      if (c == SYNC + 2) oe_late = miso_oe;
    end
  endtask

  task automatic frame(input logic [15:0] w, input int nbits);
    spi_start(w);
    for (int i = 0; i < nbits; i++) spi_bit();
    spi_end();
  endtask

  initial begin
    nrst      = 1'b0;
    spck      = 1'b0;
    ncs       = 1'b1;
    mosi      = 1'b0;
    conf_word = 8'h4C;
    divisor   = 8'h12;
    conf_enio = 8'h34;
    status    = 8'h00;
    tick(4);
    chk("reset_miso", {31'd0, miso}, 32'd0);
    chk("reset_oe", {31'd0, miso_oe}, 32'd0);
    chk("reset_rd_done", {31'd0, rd_done}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    nrst = 1'b1;
    tick(10);

    // Read addr 0: conf_word 4C
    frame(16'h8000, 16);
    chk("rd0_byte", {24'd0, rx_byte}, 32'h4C);
    chk("rd0_oe_hdr", {31'd0, oe_hdr}, 32'd0);
    chk("rd0_oe_data", {31'd0, oe_data}, 32'd1);
    chk("rd0_rd_done", n_rd, 32'd1);
    chk("rd0_frame_err", n_err, 32'd0);
    chk("rd0_oe_after", {31'd0, oe_late}, 32'd0);

    // Read addr 1 and 2
    frame(16'h8100, 16);
    chk("rd1_byte", {24'd0, rx_byte}, 32'h12);
    frame(16'h8200, 16);
    chk("rd2_byte", {24'd0, rx_byte}, 32'h34);

    // frame_cnt value before this frame: 3
    frame(16'h8400, 16);
    chk("rd4_byte_a", {24'd0, rx_byte}, 32'h03);

    // Write frame: counted, never drives miso
    frame(16'h1023, 16);
    chk("wr_oe_hdr", {31'd0, oe_hdr}, 32'd0);
    chk("wr_oe_data", {31'd0, oe_data}, 32'd0);
    chk("wr_rd_done", n_rd, 32'd0);
    chk("wr_frame_err", n_err, 32'd0);
    frame(16'h8400, 16);
    chk("rd4_byte_b", {24'd0, rx_byte}, 32'h05);

    // 10-bit aborted read
    frame(16'h8000, 10);
    chk("abort_frame_err", n_err, 32'd1);
    chk("abort_rd_done", n_rd, 32'd0);
    chk("abort_oe_after", {31'd0, oe_late}, 32'd0);
    frame(16'h8500, 16);
    chk("rd5_byte_a", {24'd0, rx_byte}, 32'h01);

    // 17-bit frame is also malformed
    frame(16'h8000, 17);
    chk("long_frame_err", n_err, 32'd1);
    chk("long_rd_done", n_rd, 32'd0);

    // Snapshot: status changes after rise 10 must not alter the byte
    status = 8'hFF;
    spi_start(16'h8300);
    for (int i = 0; i < 10; i++) spi_bit();
    status = 8'h00;
    for (int i = 0; i < 6; i++) spi_bit();
    spi_end();
    chk("snap_byte", {24'd0, rx_byte}, 32'hFF);
    chk("snap_rd_done", n_rd, 32'd1);

    // Unmapped address
    frame(16'h8900, 16);
    chk("rd9_byte", {24'd0, rx_byte}, 32'h00);
    chk("rd9_oe_data", {31'd0, oe_data}, 32'd1);

    // Reset at rise 12 of a read
    spi_start(16'h8000);
    for (int i = 0; i < 11; i++) spi_bit();
    chk("rst_pre_oe", {31'd0, oe_data}, 32'd1);
    chk("rst_pre_bits", {29'd0, rx_byte[2:0]}, 32'd2);
    mosi = 1'b0;
    tick(PH);
    spck = 1'b1;
    tick(2);
    nrst = 1'b0;
    #1;
    chk("rst_mid_oe", {31'd0, miso_oe}, 32'd0);
    chk("rst_mid_miso", {31'd0, miso}, 32'd0);
    tick(2);
    nrst = 1'b1;
    tick(PH - 4);
    spck = 1'b0;
    bit_idx = 12;
    for (int i = 0; i < 4; i++) spi_bit();
    spi_end();
    chk("rst_tail_rd_done", n_rd, 32'd0);
    chk("rst_tail_frame_err", n_err, 32'd0);
    frame(16'h8400, 16);
    chk("rst_rd4_byte", {24'd0, rx_byte}, 32'h00);
    frame(16'h8000, 16);
    chk("rst_rd0_byte", {24'd0, rx_byte}, 32'h4C);
    chk("rst_rd0_rd_done", n_rd, 32'd1);

    // err_cnt saturation: 1 long + 299 short bad frames after reset
    frame(16'h0000, 17);
    for (int k = 0; k < 299; k++) frame(16'h0000, 1);
    frame(16'h8500, 16);
    chk("rd5_sat", {24'd0, rx_byte}, 32'hFF);

    // frame_cnt wrap: 257 good frames from reset
    nrst = 1'b0;
    tick(2);
    nrst = 1'b1;
    tick(10);
    for (int k = 0; k < 257; k++) frame(16'h1000, 16);
    frame(16'h8400, 16);
    chk("rd4_wrap", {24'd0, rx_byte}, 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_readback.md
# spi_readback

SPI slave readback transmitter: the ARM-to-FPGA return path over `miso`, complementing the existing 16-bit SPI command receiver. It oversamples `spck`/`ncs`/`mosi` in the `ck_1356meg` domain, decodes read frames and shifts the selected 8-bit register out MSB-first during the same frame. It also counts completed and malformed frames for link diagnostics. It sits in the top level beside the configuration register receiver and drives the `miso` pin.

## Interface
- `SYNC_STAGES`, 2, synchronizer depth for `spck`, `ncs`, `mosi` (≥2).
- `CMD_READ`, 4'b1000, frame bits [15:12] value that selects a read.
- `ck_1356meg`  in  1  sole clock (13.56 MHz); all logic on rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `spck`  in  1  SPI clock from ARM, asynchronous to `ck_1356meg`.
- `ncs`  in  1  SPI chip select, active-low, asynchronous.
- `mosi`  in  1  SPI data from ARM, asynchronous.
- `conf_word`  in  8  readback source, addr 0.
- `divisor`  in  8  readback source, addr 1.
- `conf_enio`  in  8  readback source, addr 2.
- `status`  in  8  live status byte, addr 3.
- `miso`  out  1  SPI data to ARM.
- `miso_oe`  out  1  high while `miso` carries read data.
- `rd_done`  out  1  one-cycle pulse: read frame completed with 16 bits.
- `frame_err`  out  1  one-cycle pulse: frame ended with 1..15 or >16 bits.

## Operation
- Frame: `ncs` low, 16 bits MSB-first, SPI mode 0 (ARM samples `miso` on `spck` rise; block changes `miso` after `spck` fall). Bits [15:12] command, [11:8] address, [7:0] data slot.
- Synchronized signals: `s_spck`, `s_ncs`, `s_mosi`. Rise = `s_spck` 0→1 with `s_ncs` low; fall = 1→0 with `s_ncs` low.
- `bit_cnt` 5 bits, cleared while `s_ncs` high, +1 per rise, saturates at 31. `rx_shift` 8 bits captures `s_mosi` on each rise.
- FSM states: IDLE, HDR, DATA, DRAIN.
  - IDLE: `s_ncs` falling → HDR.
  - HDR: after 8th rise, if `rx_shift[7:4]==CMD_READ`: latch source for `rx_shift[3:0]` into `tx_shift`, `miso_oe`=1, `miso`=`tx_shift[7]`, → DATA. Otherwise → DRAIN, `miso_oe` stays 0.
  - DATA: each fall shifts `tx_shift` left, zero fill; `miso`=`tx_shift[7]`. After 16th rise → DRAIN; `miso_oe` held until `s_ncs` high.
  - DRAIN: ignore further edges.
  - Any state, `s_ncs` rising → IDLE, `miso`=0, `miso_oe`=0.
- Address map: 0 `conf_word`, 1 `divisor`, 2 `conf_enio`, 3 `status`, 4 `frame_cnt`, 5 `err_cnt`, 6–15 8'h00. The snapshot is taken once at decode; source changes during DATA do not alter the shifted byte.
- On `s_ncs` rising:
  - `bit_cnt==16`: `frame_cnt` +1 (8-bit, wraps 255→0) for any command. `rd_done` pulses if the frame was a read.
  - `bit_cnt` 1..15 or >16: `frame_err` pulses, `err_cnt` +1, saturating at 255.
  - `bit_cnt==0`: no effect.
- Counters update in the same cycle the pulse is issued. A read of addr 4/5 returns the value before the current frame's own count.

## Timing
- Reset (`nrst` low, immediate): `miso`=0, `miso_oe`=0, `rd_done`=0, `frame_err`=0, `frame_cnt`=0, `err_cnt`=0, `bit_cnt`=0, `tx_shift`=0, FSM=IDLE. Deassertion mid-frame: wait for `s_ncs` high before accepting a frame.
- Edge detect latency: SYNC_STAGES+1 cycles from pin edge.
- `miso` valid ≤ SYNC_STAGES+2 cycles after `spck` fall (or after 8th rise for bit 7).
- ARM constraints: `spck` high and low phases ≥ SYNC_STAGES+3 cycles (≥370 ns at default); first `spck` rise ≥ SYNC_STAGES+3 cycles after `ncs` fall; `ncs` high ≥ SYNC_STAGES+2 cycles between frames.
- `rd_done`/`frame_err` assert SYNC_STAGES+1 cycles after `ncs` rise, exactly one cycle wide, mutually exclusive.

## Test plan
- Read addr 0 with `conf_word`=8'h4C, frame 16'h8000 → `miso` on rises 9..16 = 0,1,0,0,1,1,0,0; `miso_oe` high rise 9 to `ncs` rise; `rd_done` one pulse; addr 4 then reads 8'h01.
- Write frame 16'h1023 → `miso_oe` never high, no `rd_done`; `frame_cnt` increments; addr 4 read returns 8'h01.
- 10-bit aborted frame → `miso_oe` drops within SYNC_STAGES+2 cycles of `ncs` rise, `frame_err` one pulse; addr 5 read returns 8'h01.
- Read addr 3, `status` toggles 8'hFF→8'h00 after rise 10 → shifted byte 8'hFF; addr 9 → 8'h00 with `miso_oe` high.
- 300 bad frames then read addr 5 → 8'hFF; 257 good frames from reset, then read addr 4 → 8'h01 (wrap).
- `nrst` low at rise 12 of a read → `miso`/`miso_oe` 0 immediately; rest of frame ignored; next full read is correct with `frame_cnt`=0.
